// File: rtl/bscan_tap_ctrl.sv
// Boundary-scan TAP controller: 16-state TAP FSM, instruction register,
// bypass and IDCODE data registers, boundary-cell strobes and tdo mux.
module bscan_tap_ctrl #(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1BA0_3477
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tms,
  input  logic                tdi,
  input  logic                bsr_so,
  output logic                tdo,
  output logic                tdo_en,
  output logic                capture_en,
  output logic                shift_dr,
  output logic                update_en,
  output logic                mode,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] instr
);

  typedef enum logic [3:0] {
    S_TLR    = 4'hF,
    S_RTI    = 4'hC,
    S_SEL_DR = 4'h7,
    S_CAP_DR = 4'h6,
    S_SH_DR  = 4'h2,
    S_EX1_DR = 4'h1,
    S_PAU_DR = 4'h3,
    S_EX2_DR = 4'h0,
    S_UPD_DR = 4'h5,
    S_SEL_IR = 4'h4,
    S_CAP_IR = 4'hE,
    S_SH_IR  = 4'hA,
    S_EX1_IR = 4'h9,
    S_PAU_IR = 4'hB,
    S_EX2_IR = 4'h8,
    S_UPD_IR = 4'hD
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] C_EXTEST = '0;
  localparam logic [IR_WIDTH-1:0] C_SAMPLE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] C_IDCODE = IR_WIDTH'(2);

  tap_state_t          r_state;
  tap_state_t          w_next;
  logic [IR_WIDTH-1:0] r_instr;
  logic [IR_WIDTH-1:0] r_ir_sh;
  logic                r_byp;
  logic [31:0]         r_id_sh;

  logic w_is_extest;
  logic w_is_sample;
  logic w_is_idcode;
  logic w_is_bypass;
  logic w_bsr_sel;

  // Unknown codes fall through to BYPASS so a bad IR never lengthens the chain.
  assign w_is_extest = (r_instr == C_EXTEST);
  assign w_is_sample = (r_instr == C_SAMPLE);
  assign w_is_idcode = (r_instr == C_IDCODE);
  assign w_is_bypass = ~(w_is_extest | w_is_sample | w_is_idcode);
  assign w_bsr_sel   = w_is_extest | w_is_sample;

  always_comb begin
    w_next = S_TLR;
    unique case (r_state)
      S_TLR:    w_next = tms ? S_TLR    : S_RTI;
      S_RTI:    w_next = tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: w_next = tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: w_next = tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  w_next = tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: w_next = tms ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: w_next = tms ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: w_next = tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: w_next = tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: w_next = tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: w_next = tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  w_next = tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: w_next = tms ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: w_next = tms ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: w_next = tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: w_next = tms ? S_SEL_DR : S_RTI;
      default:  w_next = S_TLR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_TLR;
      r_instr <= C_IDCODE;
      r_ir_sh <= '0;
      r_byp   <= 1'b0;
      r_id_sh <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_CAP_IR: r_ir_sh <= IR_WIDTH'(1);
        S_SH_IR:  r_ir_sh <= {tdi, r_ir_sh[IR_WIDTH-1:1]};
        S_UPD_IR: r_instr <= r_ir_sh;
        S_CAP_DR: begin
          r_id_sh <= IDCODE_VAL;
          if (w_is_bypass) r_byp <= 1'b0;
        end
        S_SH_DR: begin
          r_id_sh <= {tdi, r_id_sh[31:1]};
          if (w_is_bypass) r_byp <= tdi;
        end
        default: ;
      endcase
      // Loading IDCODE on entry (not only while resident) makes the TMS escape
      // land in TLR with IDCODE already active.
      if (w_next == S_TLR) r_instr <= C_IDCODE;
    end
  end

  assign tap_state  = r_state;
  assign instr      = r_instr;
  assign tdo_en     = (r_state == S_SH_DR) || (r_state == S_SH_IR);
  assign capture_en = (r_state == S_CAP_DR) && w_bsr_sel;
  assign shift_dr   = (r_state == S_SH_DR) && w_bsr_sel;
  assign update_en  = (r_state == S_UPD_DR) && w_bsr_sel;
  assign mode       = w_is_extest;

  always_comb begin
    tdo = 1'b0;
    if (r_state == S_SH_IR) begin
      tdo = r_ir_sh[0];
    end else if (r_state == S_SH_DR) begin
      if (w_bsr_sel)        tdo = bsr_so;
      else if (w_is_idcode) tdo = r_id_sh[0];
      else                  tdo = r_byp;
    end
  end

endmodule

// File: tb/tb_bscan_tap_ctrl.sv
// Directed bench for bscan_tap_ctrl: reset, IDCODE readout, BYPASS, EXTEST,
// pause hold, TMS escape and reset abort.
module tb_bscan_tap_ctrl;

  localparam int          W      = 4;
  localparam logic [31:0] ID_VAL = 32'h1BA0_3477;

  logic         clk;
  logic         rst_n;
  logic         tms;
  logic         tdi;
  logic         bsr_so;
  logic         tdo;
  logic         tdo_en;
  logic         capture_en;
  logic         shift_dr;
  logic         update_en;
  logic         mode;
  logic [3:0]   tap_state;
  logic [W-1:0] instr;

  int n_pass;
  int n_total;

  bscan_tap_ctrl #(.IR_WIDTH(W), .IDCODE_VAL(ID_VAL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tms        (tms),
    .tdi        (tdi),
    .bsr_so     (bsr_so),
    .tdo        (tdo),
    .tdo_en     (tdo_en),
    .capture_en (capture_en),
    .shift_dr   (shift_dr),
    .update_en  (update_en),
    .mode       (mode),
    .tap_state  (tap_state),
    .instr      (instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge clk);
    #1;
  endtask

  task automatic go_tlr();
    repeat (5) tick(1'b1, 1'b0);
  endtask

  // From RTI: shift code into IR, pass UpdIR, return to RTI.
  task automatic load_ir(input logic [W-1:0] code);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < W; i++) tick(i == W - 1, code[i]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    n_total++;
    if (tap_state !== 4'h2) $display("FAIL pre_reset_state got %h want 2", tap_state);
    else n_pass++;
    #3;
    rst_n = 1'b0;
    tms   = 1'b1;
    #1;
    n_total++;
    if (tap_state !== 4'hF) $display("FAIL reset_state got %h want F", tap_state);
    else n_pass++;
    n_total++;
    if (instr !== 4'h2) $display("FAIL reset_instr got %h want 2", instr);
    else n_pass++;
    n_total++;
    if ({tdo, tdo_en, capture_en, shift_dr, update_en, mode} !== 6'b0)
      $display("FAIL reset_outputs got %b want 000000",
               {tdo, tdo_en, capture_en, shift_dr, update_en, mode});
    else n_pass++;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (tap_state !== 4'hF) $display("FAIL release_state got %h want F", tap_state);
    else n_pass++;
  endtask

  task automatic test_idcode();
    logic [31:0] got;
    logic        en_ok;
    got   = '0;
    en_ok = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_total++;
    if (capture_en !== 1'b0) $display("FAIL idcode_capture_en got %b want 0", capture_en);
    else n_pass++;
    tick(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      got[i] = tdo;
      if (tdo_en !== 1'b1) en_ok = 1'b0;
      tick(1'b0, 1'b0);
    end
    n_total++;
    if (got !== ID_VAL) $display("FAIL idcode_stream got %h want %h", got, ID_VAL);
    else n_pass++;
    n_total++;
    if (en_ok !== 1'b1) $display("FAIL idcode_tdo_en got 0 want 1");
    else n_pass++;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_bypass();
    logic [7:0] pat;
    logic [7:0] echo;
    logic       b0;
    logic       b1;
    pat  = 8'b1011_0010;
    echo = '0;
    go_tlr();
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    n_total++;
    if (tap_state !== 4'hA || tdo_en !== 1'b1)
      $display("FAIL shir_entry got state %h en %b want A 1", tap_state, tdo_en);
    else n_pass++;
    b0 = tdo;
    tick(1'b0, 1'b1);
    b1 = tdo;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    n_total++;
    if ({b0, b1} !== 2'b10) $display("FAIL ir_capture_bits got %b want 10", {b0, b1});
    else n_pass++;
    tick(1'b1, 1'b0);
    n_total++;
    if (tap_state !== 4'hD || instr !== 4'h2)
      $display("FAIL updir_state got state %h instr %h want D 2", tap_state, instr);
    else n_pass++;
    tick(1'b0, 1'b0);
    n_total++;
    if (instr !== 4'hF || mode !== 1'b0)
      $display("FAIL bypass_instr got instr %h mode %b want F 0", instr, mode);
    else n_pass++;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    n_total++;
    if (tdo !== 1'b0) $display("FAIL bypass_capture got %b want 0", tdo);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, pat[i]);
      echo[i] = tdo;
    end
    n_total++;
    if (echo !== pat) $display("FAIL bypass_echo got %b want %b", echo, pat);
    else n_pass++;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_extest();
    int   n_sh;
    logic so_ok;
    n_sh  = 0;
    so_ok = 1'b1;
    load_ir(4'h0);
    n_total++;
    if (instr !== 4'h0 || mode !== 1'b1)
      $display("FAIL extest_load got instr %h mode %b want 0 1", instr, mode);
    else n_pass++;
    tick(1'b1, 1'b0);
    n_total++;
    if (capture_en !== 1'b0) $display("FAIL extest_seldr_cap got %b want 0", capture_en);
    else n_pass++;
    tick(1'b0, 1'b0);
    n_total++;
    if (capture_en !== 1'b1 || shift_dr !== 1'b0)
      $display("FAIL extest_capdr got cap %b sh %b want 1 0", capture_en, shift_dr);
    else n_pass++;
    tick(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (shift_dr === 1'b1 && capture_en === 1'b0) n_sh++;
      bsr_so = 1'b1;
      #1;
      if (tdo !== 1'b1) so_ok = 1'b0;
      bsr_so = 1'b0;
      #1;
      if (tdo !== 1'b0) so_ok = 1'b0;
      tick(i == 4, 1'b0);
    end
    n_total++;
    if (n_sh !== 5) $display("FAIL extest_shift_cycles got %0d want 5", n_sh);
    else n_pass++;
    n_total++;
    if (so_ok !== 1'b1) $display("FAIL extest_tdo_bsr_so got 0 want 1");
    else n_pass++;
    n_total++;
    if (shift_dr !== 1'b0 || update_en !== 1'b0)
      $display("FAIL extest_ex1dr got sh %b upd %b want 0 0", shift_dr, update_en);
    else n_pass++;
    tick(1'b1, 1'b0);
    n_total++;
    if (update_en !== 1'b1) $display("FAIL extest_update got %b want 1", update_en);
    else n_pass++;
    tick(1'b0, 1'b0);
    n_total++;
    if (update_en !== 1'b0 || tap_state !== 4'hC)
      $display("FAIL extest_after_upd got upd %b state %h want 0 C", update_en, tap_state);
    else n_pass++;
  endtask

  task automatic test_pause();
    logic [31:0] got;
    logic        hold_ok;
    got     = '0;
    hold_ok = 1'b1;
    go_tlr();
    n_total++;
    if (instr !== 4'h2 || mode !== 1'b0)
      $display("FAIL tlr_instr got instr %h mode %b want 2 0", instr, mode);
    else n_pass++;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      got[i] = tdo;
      tick(i == 9, 1'b0);
    end
    tick(1'b0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      if (tap_state !== 4'h3 || shift_dr !== 1'b0 || tdo_en !== 1'b0) hold_ok = 1'b0;
      tick(j == 9, 1'b1);
    end
    tick(1'b0, 1'b0);
    for (int i = 10; i < 32; i++) begin
      got[i] = tdo;
      tick(1'b0, 1'b0);
    end
    n_total++;
    if (hold_ok !== 1'b1) $display("FAIL pause_hold got 0 want 1");
    else n_pass++;
    n_total++;
    if (got !== ID_VAL) $display("FAIL pause_stream got %h want %h", got, ID_VAL);
    else n_pass++;
  endtask

  task automatic test_escape();
    int n_upd;
    n_upd = 0;
    go_tlr();
    tick(1'b0, 1'b0);
    load_ir(4'h0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    n_total++;
    if (tap_state !== 4'h2 || mode !== 1'b1)
      $display("FAIL escape_entry got state %h mode %b want 2 1", tap_state, mode);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      if (update_en === 1'b1) n_upd++;
    end
    n_total++;
    if (tap_state !== 4'hF || instr !== 4'h2 || mode !== 1'b0)
      $display("FAIL escape_tlr got state %h instr %h mode %b want F 2 0",
               tap_state, instr, mode);
    else n_pass++;
    n_total++;
    if (n_upd !== 1) $display("FAIL escape_update_pulses got %0d want 1", n_upd);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    tick(1'b0, 1'b0);
    load_ir(4'h0);
    n_total++;
    if (instr !== 4'h0) $display("FAIL abort_preload got %h want 0", instr);
    else n_pass++;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    n_total++;
    if (tap_state !== 4'hA) $display("FAIL abort_in_shir got %h want A", tap_state);
    else n_pass++;
    #3;
    rst_n = 1'b0;
    tms   = 1'b1;
    #1;
    n_total++;
    if (tap_state !== 4'hF || instr !== 4'h2 || mode !== 1'b0)
      $display("FAIL abort_reset got state %h instr %h mode %b want F 2 0",
               tap_state, instr, mode);
    else n_pass++;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick(1'b0, 1'b0);
    n_total++;
    if (tap_state !== 4'hC || instr !== 4'h2)
      $display("FAIL abort_after got state %h instr %h want C 2", tap_state, instr);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    tms     = 1'b1;
    tdi     = 1'b0;
    bsr_so  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_idcode();
    test_bypass();
    test_extest();
    test_pause();
    test_escape();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
